sopc_verin_debug_access_arbiter: RTL
====================================

# sopc_verin_debug_access_arbiter

Two-requester arbiter and sequencer for the Nios II debug access path of the SOPC_verin system. It shares a single debug resource port between the JTAG command decoder (requester 0) and an Avalon-side debug register bridge (requester 1). The resource port covers OCI memory read/write and break set/clear. The block serialises commands, enforces one outstanding access, applies a completion timeout and routes each response back to its originator.

## Interface
- ADDR_W, 8, resource address width
- DATA_W, 32, data width (matches MonDReg)
- TIMEOUT, 255, maximum WAIT cycles before abort (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req0_valid / req1_valid  in  1  command request
- req0_ready / req1_ready  out  1  command accepted this cycle
- req0_op / req1_op  in  2  opcode
- req0_addr / req1_addr  in  ADDR_W  target address
- req0_wdata / req1_wdata  in  DATA_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_id  out  1  originating requester
- rsp_rdata  out  DATA_W  read data
- rsp_err  out  1  resource error or timeout
- res_cmd_valid  out  1  one-cycle command strobe to resource
- res_op  out  2  registered opcode
- res_addr  out  ADDR_W  registered address
- res_wdata  out  DATA_W  registered write data
- res_done  in  1  resource completion pulse
- res_rdata  in  DATA_W  valid with res_done
- res_error  in  1  valid with res_done
- busy  out  1  state ≠ IDLE

## Operation
- Opcodes: 0 MEM_RD, 1 MEM_WR, 2 BRK_SET, 3 BRK_CLR. All four are legal.
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - reqN_ready is asserted only for the arbitration winner, combinationally from the valids and last_grant.
  - On handshake, latch op/addr/wdata/id and go to ISSUE.
- Arbitration:
  - A single requester always wins.
  - If both are valid, the winner is the requester not equal to last_grant.
  - last_grant updates on each accept.
- ISSUE: assert res_cmd_valid for exactly one cycle, clear the timeout counter, go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - On res_done: capture rsp_rdata = res_rdata (forced 0 for MEM_WR/BRK_SET/BRK_CLR), rsp_err = res_error, go to RESP.
  - If res_done is absent on the TIMEOUT-th WAIT cycle: rsp_rdata = 0, rsp_err = 1, go to RESP.
- RESP: hold rsp_valid/rsp_id/rsp_rdata/rsp_err stable until rsp_ready, then go to IDLE.
- res_done outside WAIT (late or spurious) is ignored.
- res_op/res_addr/res_wdata hold the last command until the next accept.

## Timing
- Reset values: all ready/valid/strobe outputs 0, busy 0, rsp_* 0, res_* 0, state IDLE, last_grant 1 (requester 0 wins first contest).
- Minimum latency:
  - Accept at cycle N.
  - res_cmd_valid at N+1.
  - res_done at N+2 (earliest sampled).
  - rsp_valid at N+3.
- The resource guarantees ≥1 cycle between strobe and done. Done coincident with the strobe is not sampled.
- res_done on the TIMEOUT-th WAIT cycle counts as success; timeout fires only if done is absent on that cycle.
- Counter width: $clog2(TIMEOUT+1). It saturates and never wraps.
- rsp_ready asserted in the first RESP cycle gives a one-cycle response. Next accept is possible the cycle after the response handshake.
- No request is accepted while busy. Requesters hold valid and payload until ready.
- Reset mid-operation:
  - Abandon the command, with no response and no further strobe.
  - Return to IDLE with the reset values above, last_grant = 1.

## Structure
- Shared package sopc_verin_dbg_pkg:
  - opcode constants
  - FSM state encoding
  - requester ID constants
- Sub-module sopc_verin_dbg_rr_arb: 2-way round-robin grant with last_grant register and accept-driven update.
- FSM, payload registers and timeout counter live in the top block.

## Test plan
- Single requester: req0 MEM_RD addr 0x10, resource returns done one cycle after strobe with rdata 0xDEADBEEF → rsp_valid at N+3, rsp_id 0, rdata 0xDEADBEEF, err 0.
- Contention: both valid continuously for 4 commands → grants 0,1,0,1; exactly one res_cmd_valid per command.
- Timeout: TIMEOUT = 4, res_done never asserted → rsp_err 1, rdata 0 after 4 WAIT cycles. Done on cycle 4 instead → err 0.
- Backpressure and spurious done: rsp_ready held low 10 cycles → rsp_* stable, req ready low, busy 1. res_done pulsed during RESP is ignored.
- Write op with error: req1 MEM_WR, done with res_error 1 and res_rdata 0x1234 → rsp_rdata 0, rsp_err 1, rsp_id 1.
- Reset during WAIT → next cycle all outputs 0, no response emitted. Next contest is won by req0.

Source files
------------

// File: rtl/sopc_verin_dbg_pkg.sv
// Shared definitions for the SOPC_verin Nios II debug access path:
// resource opcodes, sequencer state encoding and requester identities.
package sopc_verin_dbg_pkg;

    typedef enum logic [1:0] {
        OP_MEM_RD  = 2'd0,
        OP_MEM_WR  = 2'd1,
        OP_BRK_SET = 2'd2,
        OP_BRK_CLR = 2'd3
    } dbg_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } dbg_state_e;

    localparam logic REQ_JTAG   = 1'b0;
    localparam logic REQ_AVALON = 1'b1;

    // Only memory reads carry resource data back to the requester.
    function automatic logic op_returns_data(input logic [1:0] op);
        return op == OP_MEM_RD;
    endfunction

endpackage

// File: rtl/sopc_verin_dbg_rr_arb.sv
// Two-way round-robin grant between the JTAG decoder and the Avalon bridge.
// last_grant advances only on an accepted request.
module sopc_verin_dbg_rr_arb
    import sopc_verin_dbg_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1,
    output logic grant_id,
    output logic accept
);

    logic last_grant;

    always_comb begin
        grant0   = enable && valid0 && (!valid1 || last_grant == REQ_AVALON);
        grant1   = enable && valid1 && (!valid0 || last_grant == REQ_JTAG);
        accept   = grant0 || grant1;
        grant_id = grant1 ? REQ_AVALON : REQ_JTAG;
    end

    // Reset to requester 1 so requester 0 wins the first contest.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= REQ_AVALON;
        end else if (accept) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/sopc_verin_debug_access_arbiter.sv
// Serialises debug resource commands from two requesters, enforces a single
// outstanding access with a completion timeout and routes the response back.
module sopc_verin_debug_access_arbiter
    import sopc_verin_dbg_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_op,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_op,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              res_cmd_valid,
    output logic [1:0]        res_op,
    output logic [ADDR_W-1:0] res_addr,
    output logic [DATA_W-1:0] res_wdata,
    input  logic              res_done,
    input  logic [DATA_W-1:0] res_rdata,
    input  logic              res_error,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    dbg_state_e       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             cur_id;
    logic             grant0;
    logic             grant1;
    logic             grant_id;
    logic             accept;

    sopc_verin_dbg_rr_arb u_arb (
        .clk      (clk),
        .reset    (reset),
        .enable   (state == ST_IDLE),
        .valid0   (req0_valid),
        .valid1   (req1_valid),
        .grant0   (grant0),
        .grant1   (grant1),
        .grant_id (grant_id),
        .accept   (accept)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            cur_id        <= REQ_JTAG;
            busy          <= 1'b0;
            res_cmd_valid <= 1'b0;
            res_op        <= '0;
            res_addr      <= '0;
            res_wdata     <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
        end else begin
            res_cmd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state         <= ST_ISSUE;
                        busy          <= 1'b1;
                        res_cmd_valid <= 1'b1;
                        cur_id        <= grant_id;
                        res_op        <= grant1 ? req1_op    : req0_op;
                        res_addr      <= grant1 ? req1_addr  : req0_addr;
                        res_wdata     <= grant1 ? req1_wdata : req0_wdata;
                    end
                end
                ST_ISSUE: begin
                    state    <= ST_WAIT;
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                    // Done on the last allowed cycle still wins over the timeout.
                    if (res_done) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id;
                        rsp_rdata <= op_returns_data(res_op) ? res_rdata : '0;
                        rsp_err   <= res_error;
                    end else if (wait_cnt == CNT_LAST) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
